i2c_req_arbiter: RTL and testbench

Round-robin scheduler that shares one I2C master among N requesters. Each requester presents a 32-bit I2C config word {device_addr, reg_addr_hi, reg_addr_lo, wr_data}. The arbiter grants one request at a time, drives the master's start/config inputs, and waits for the master's done. It then returns completion, read byte and a timeout error flag to the owning requester. It sits between the EEPROM/sensor control blocks and the single I2C master.

---
 rtl/i2c_arb_pkg.sv | 36 +++
 rtl/i2c_req_arbiter_rr_pick.sv | 27 ++
 rtl/i2c_req_arbiter.sv | 121 ++++++++++++
 tb/tb_i2c_req_arbiter.sv | 315 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/i2c_arb_pkg.sv
// Shared types and constants for the I2C request arbiter.
package i2c_arb_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        GAP  = 2'd2
    } state_t;

    // Config word layout: {device_addr, reg_addr_hi, reg_addr_lo, wr_data}
    localparam int DEV_MSB     = 31;
    localparam int DEV_LSB     = 24;
    localparam int ADDR_HI_MSB = 23;
    localparam int ADDR_HI_LSB = 16;
    localparam int ADDR_LO_MSB = 15;
    localparam int ADDR_LO_LSB = 8;
    localparam int DATA_MSB    = 7;
    localparam int DATA_LSB    = 0;

    localparam logic [19:0] TO_MAX_DEFAULT = 20'hF_FFFF;

    // Assemble a config word from its four byte fields.
    function automatic logic [31:0] make_cfg(input logic [7:0] dev,
                                             input logic [7:0] addr_hi,
                                             input logic [7:0] addr_lo,
                                             input logic [7:0] data);
        logic [31:0] w;
        w                          = '0;
        w[DEV_MSB:DEV_LSB]         = dev;
        w[ADDR_HI_MSB:ADDR_HI_LSB] = addr_hi;
        w[ADDR_LO_MSB:ADDR_LO_LSB] = addr_lo;
        w[DATA_MSB:DATA_LSB]       = data;
        return w;
    endfunction

endpackage

// File: rtl/i2c_req_arbiter_rr_pick.sv
// Combinational round-robin picker: first requester after last_grant, wrapping.
module rr_pick #(
    parameter int N = 4
) (
    input  logic [N-1:0]         req,
    input  logic [$clog2(N)-1:0] last_grant,
    output logic [$clog2(N)-1:0] grant,
    output logic                 valid
);
    localparam int IW = $clog2(N);

    // Scan N positions starting one past the previous winner; first hit wins.
    always_comb begin
        logic [IW-1:0] idx;
        idx   = '0;
        grant = '0;
        valid = 1'b0;
        for (int i = 1; i <= N; i++) begin
            idx = IW'((int'(last_grant) + i) % N);
            if (!valid && req[idx]) begin
                valid = 1'b1;
                grant = idx;
            end
        end
    end

endmodule

// File: rtl/i2c_req_arbiter.sv
// Shares one I2C master among N requesters with round-robin arbitration and
// a per-transaction watchdog.
//
// state | meaning
// IDLE  | waiting for any req; arbitration happens here only
// BUSY  | transaction owned by last_grant, i2c_start held high
// GAP   | one recovery cycle for the master before re-arbitration
module i2c_req_arbiter
    import i2c_arb_pkg::*;
#(
    parameter int              N      = 4,
    parameter int              TO_W   = 20,
    parameter logic [TO_W-1:0] TO_MAX = TO_W'(TO_MAX_DEFAULT)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [N-1:0]    req,
    input  logic [32*N-1:0] req_data,
    output logic [N-1:0]    ack,
    output logic [N-1:0]    done,
    output logic [7:0]      rd_byte,
    output logic            err,
    output logic            busy,
    output logic            i2c_start,
    output logic [31:0]     i2c_config_data,
    input  logic            i2c_done,
    input  logic [7:0]      i2c_rd_data
);
    localparam int              IW       = $clog2(N);
    localparam logic [TO_W-1:0] WD_LIMIT = TO_MAX - TO_W'(1);

    state_t          state, state_next;
    logic [IW-1:0]   last_grant;
    logic [IW-1:0]   pick_grant;
    logic            pick_valid;
    logic [TO_W-1:0] wd, wd_next;
    logic [N-1:0]    ack_next, done_next;
    logic            err_next, start_next, cfg_load, rd_load;

    rr_pick #(.N(N)) u_pick (
        .req        (req),
        .last_grant (last_grant),
        .grant      (pick_grant),
        .valid      (pick_valid)
    );

    assign busy = (state != IDLE);

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    // Next-state and registered-output decisions.
    always_comb begin
        state_next = state;
        wd_next    = wd;
        ack_next   = '0;
        done_next  = '0;
        err_next   = 1'b0;
        start_next = i2c_start;
        cfg_load   = 1'b0;
        rd_load    = 1'b0;
        case (state)
            IDLE: begin
                if (pick_valid) begin
                    state_next           = BUSY;
                    ack_next[pick_grant] = 1'b1;
                    start_next           = 1'b1;
                    cfg_load             = 1'b1;
                    wd_next              = '0;
                end
            end
            BUSY: begin
                // A real completion beats a watchdog expiry on the same edge.
                if (i2c_done) begin
                    state_next            = GAP;
                    start_next            = 1'b0;
                    rd_load               = 1'b1;
                    done_next[last_grant] = 1'b1;
                end else if (wd == WD_LIMIT) begin
                    state_next            = GAP;
                    start_next            = 1'b0;
                    err_next              = 1'b1;
                    done_next[last_grant] = 1'b1;
                end else begin
                    wd_next = wd + TO_W'(1);
                end
            end
            GAP:     state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Datapath and output registers; last_grant doubles as the current owner.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            last_grant      <= IW'(N - 1);
            wd              <= '0;
            ack             <= '0;
            done            <= '0;
            err             <= 1'b0;
            i2c_start       <= 1'b0;
            i2c_config_data <= '0;
            rd_byte         <= '0;
        end else begin
            wd        <= wd_next;
            ack       <= ack_next;
            done      <= done_next;
            err       <= err_next;
            i2c_start <= start_next;
            if (cfg_load) begin
                last_grant      <= pick_grant;
                i2c_config_data <= req_data[32*pick_grant +: 32];
            end
            if (rd_load) rd_byte <= i2c_rd_data;
        end
    end

endmodule

// File: tb/tb_i2c_req_arbiter.sv
// Scoreboard bench for i2c_req_arbiter with a simple I2C master responder.
module tb_i2c_req_arbiter;
    import i2c_arb_pkg::*;

    localparam int N = 4;

    typedef struct {
        logic [N-1:0] vec;
        logic [31:0]  cfg;
    } ack_exp_t;

    typedef struct {
        logic [N-1:0] vec;
        logic         err;
        logic [7:0]   rd;
    } done_exp_t;

    logic            clk = 1'b0;
    logic            rst;
    logic [N-1:0]    req;
    logic [32*N-1:0] req_data;
    logic [N-1:0]    ack, done;
    logic [7:0]      rd_byte;
    logic            err, busy, i2c_start;
    logic [31:0]     i2c_config_data;
    logic            i2c_done;
    logic [7:0]      i2c_rd_data;

    int n_checks = 0;
    int n_errors = 0;

    ack_exp_t  exp_ack[$];
    done_exp_t exp_done[$];

    // Master responder controls
    int         resp_delay = 0;
    logic [7:0] resp_data  = 8'h00;
    logic       gap_spur   = 1'b0;
    logic       spur_req   = 1'b0;
    logic [7:0] spur_data  = 8'h00;

    i2c_req_arbiter #(.N(N), .TO_W(20), .TO_MAX(20'd16)) dut (
        .clk             (clk),
        .rst             (rst),
        .req             (req),
        .req_data        (req_data),
        .ack             (ack),
        .done            (done),
        .rd_byte         (rd_byte),
        .err             (err),
        .busy            (busy),
        .i2c_start       (i2c_start),
        .i2c_config_data (i2c_config_data),
        .i2c_done        (i2c_done),
        .i2c_rd_data     (i2c_rd_data)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: observed 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic push_ack(input int g, input logic [31:0] cfg);
        ack_exp_t a;
        a.vec = '0;
        a.vec[g] = 1'b1;
        a.cfg = cfg;
        exp_ack.push_back(a);
    endtask

    task automatic push_done(input int g, input logic e, input logic [7:0] rd);
        done_exp_t d;
        d.vec = '0;
        d.vec[g] = 1'b1;
        d.err = e;
        d.rd  = rd;
        exp_done.push_back(d);
    endtask

    task automatic wait_ack(output int cyc);
        cyc = 0;
        do begin
            @(negedge clk);
            cyc++;
        end while (ack == '0 && cyc < 100);
        if (ack == '0) chk("wait_ack_expired", 0, 1);
    endtask

    task automatic wait_done(output int cyc);
        cyc = 0;
        do begin
            @(negedge clk);
            cyc++;
        end while (done == '0 && cyc < 100);
        if (done == '0) chk("wait_done_expired", 0, 1);
    endtask

    // Master model: pulses i2c_done once i2c_start has been seen high
    // resp_delay times; optional stray pulses in GAP or on request.
    initial begin
        int  hi_cnt;
        logic pend_gap;
        hi_cnt      = 0;
        pend_gap    = 1'b0;
        i2c_done    = 1'b0;
        i2c_rd_data = 8'h00;
        forever begin
            @(negedge clk);
            if (i2c_start) hi_cnt++;
            else           hi_cnt = 0;
            if (i2c_start && resp_delay != 0 && hi_cnt == resp_delay) begin
                i2c_done    = 1'b1;
                i2c_rd_data = resp_data;
                pend_gap    = gap_spur;
            end else if (pend_gap) begin
                i2c_done    = 1'b1;
                i2c_rd_data = 8'hEE;
                pend_gap    = 1'b0;
            end else if (spur_req) begin
                i2c_done    = 1'b1;
                i2c_rd_data = spur_data;
                spur_req    = 1'b0;
            end else begin
                i2c_done    = 1'b0;
            end
        end
    end

    // Scoreboard monitor: every ack/done pulse is matched against the queues.
    initial begin
        ack_exp_t  a;
        done_exp_t d;
        forever begin
            @(negedge clk);
            if (ack != '0) begin
                chk("ack_onehot", $countones(ack), 1);
                if (exp_ack.size() == 0) chk("ack_unexpected", ack, 0);
                else begin
                    a = exp_ack.pop_front();
                    chk("ack_vec", ack, a.vec);
                    chk("ack_cfg", i2c_config_data, a.cfg);
                    chk("ack_start", i2c_start, 1);
                end
            end
            if (done != '0) begin
                chk("done_onehot", $countones(done), 1);
                if (exp_done.size() == 0) chk("done_unexpected", done, 0);
                else begin
                    d = exp_done.pop_front();
                    chk("done_vec", done, d.vec);
                    chk("done_err", err, d.err);
                    chk("done_rd_byte", rd_byte, d.rd);
                    chk("done_start_low", i2c_start, 0);
                end
            end else if (err) begin
                chk("err_without_done", err, 0);
            end
        end
    end

    initial begin
        int cyc;
        int cnt;
        rst      = 1'b1;
        req      = '0;
        req_data = '0;
        repeat (2) @(negedge clk);

        // Reset state
        chk("rst_ack", ack, 0);
        chk("rst_done", done, 0);
        chk("rst_err", err, 0);
        chk("rst_busy", busy, 0);
        chk("rst_start", i2c_start, 0);
        chk("rst_cfg", i2c_config_data, 0);
        chk("rst_rd_byte", rd_byte, 0);
        rst = 1'b0;
        @(negedge clk);

        // Single request
        req_data[31:0] = make_cfg(8'hA0, 8'h00, 8'h07, 8'h88);
        resp_delay = 10;
        resp_data  = 8'h55;
        push_ack(0, 32'hA000_0788);
        push_done(0, 1'b0, 8'h55);
        req = 4'b0001;
        wait_ack(cyc);
        chk("single_ack_lat", cyc, 1);
        chk("single_cfg", i2c_config_data, 32'hA000_0788);
        req = '0;
        wait_done(cyc);
        chk("single_done_lat", cyc, 10);
        chk("single_busy_gap", busy, 1);
        @(negedge clk);
        chk("single_busy_idle", busy, 0);
        repeat (2) @(negedge clk);

        // Fairness from a fresh reset: 0,1,2,3,0
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < N; i++)
            req_data[32*i +: 32] = make_cfg(8'(8'h50 + 2*i), 8'(8'h10 + i), 8'(8'h20 + i), 8'(8'h30 + i));
        resp_delay = 3;
        resp_data  = 8'h3C;
        for (int k = 0; k < 5; k++) begin
            push_ack(k % N, make_cfg(8'(8'h50 + 2*(k % N)), 8'(8'h10 + k % N), 8'(8'h20 + k % N), 8'(8'h30 + k % N)));
            push_done(k % N, 1'b0, 8'h3C);
        end
        req = 4'b1111;
        for (int k = 0; k < 5; k++) begin
            wait_ack(cyc);
            chk("rr_grant_lat", cyc, (k == 0) ? 1 : 2);
            wait_done(cyc);
            chk("rr_busy_len", cyc, 3);
        end
        req = '0;
        repeat (3) @(negedge clk);

        // Watchdog timeout, no i2c_done
        req_data[63:32] = make_cfg(8'hA1, 8'h01, 8'h02, 8'h03);
        resp_delay = 0;
        push_ack(1, 32'hA101_0203);
        push_done(1, 1'b1, 8'h3C);
        req = 4'b0010;
        wait_ack(cyc);
        req = '0;
        cnt = 0;
        while (i2c_start && cnt < 100) begin
            cnt++;
            @(negedge clk);
        end
        chk("to_start_cycles", cnt, 16);
        chk("to_done_pulse", done, 4'b0010);
        chk("to_rd_hold", rd_byte, 8'h3C);
        repeat (3) @(negedge clk);

        // Collision: i2c_done on the watchdog limit edge
        resp_delay = 16;
        resp_data  = 8'hE7;
        push_ack(2, req_data[95:64]);
        push_done(2, 1'b0, 8'hE7);
        req = 4'b0100;
        wait_ack(cyc);
        req = '0;
        wait_done(cyc);
        chk("coll_done_lat", cyc, 16);
        chk("coll_err", err, 0);
        repeat (3) @(negedge clk);

        // Spurious i2c_done in GAP
        resp_delay = 4;
        resp_data  = 8'h11;
        gap_spur   = 1'b1;
        push_ack(3, req_data[127:96]);
        push_done(3, 1'b0, 8'h11);
        req = 4'b1000;
        wait_ack(cyc);
        req = '0;
        wait_done(cyc);
        gap_spur = 1'b0;
        repeat (2) @(negedge clk);
        chk("spur_gap_done", done, 0);
        chk("spur_gap_rd", rd_byte, 8'h11);

        // Spurious i2c_done in IDLE
        spur_data = 8'h99;
        spur_req  = 1'b1;
        repeat (4) @(negedge clk);
        chk("spur_idle_rd", rd_byte, 8'h11);
        chk("spur_idle_busy", busy, 0);

        // Reset mid-BUSY
        resp_delay = 0;
        push_ack(3, req_data[127:96]);
        req = 4'b1000;
        wait_ack(cyc);
        req = '0;
        repeat (5) @(negedge clk);
        rst = 1'b1;
        #1;
        chk("midrst_start", i2c_start, 0);
        chk("midrst_busy", busy, 0);
        chk("midrst_ack", ack, 0);
        chk("midrst_done", done, 0);
        chk("midrst_err", err, 0);
        chk("midrst_cfg", i2c_config_data, 0);
        chk("midrst_rd", rd_byte, 0);
        @(negedge clk);
        resp_delay = 6;
        resp_data  = 8'h5A;
        push_ack(1, req_data[63:32]);
        push_done(1, 1'b0, 8'h5A);
        req = 4'b0110;
        rst = 1'b0;
        wait_ack(cyc);
        chk("postrst_ack_lat", cyc, 1);
        req = '0;
        wait_done(cyc);
        chk("postrst_done_lat", cyc, 6);
        repeat (3) @(negedge clk);

        chk("sb_ack_empty", exp_ack.size(), 0);
        chk("sb_done_empty", exp_done.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
